// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
  } ifid_t;

  localparam int IFID_W = $bits(ifid_t);

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID-style register: flush > load > bubble > hold. Also used as the stall hold buffer.
module fetch_ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              bubble,
  input  logic [IFID_W-1:0] d,
  output logic [IFID_W-1:0] q
);

  ifid_t q_r;

  assign q = q_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r.valid        <= 1'b0;
      q_r.pc           <= 32'h0;
      q_r.inst         <= NOP_INST;
      q_r.pred_taken   <= 1'b0;
      q_r.pred_next_pc <= 32'h0;
    end else if (flush || (bubble && !load)) begin
      // Only valid and inst are scrubbed; the other fields are don't-care once invalid.
      q_r.valid <= 1'b0;
      q_r.inst  <= NOP_INST;
    end else if (load) begin
      q_r <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request, fills IF/ID.
// state | meaning
// REQ   | request pc to memory; no fetch in flight
// WAIT  | request accepted, waiting for response
// HOLD  | response captured while ID stalled; waiting to forward it
// DROP  | redirect hit mid-fetch; swallow the stale response
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] current_pc,
  input  logic [31:0] predicted_next_pc,
  input  logic        predicted_branch_taken,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic        ifid_pred_taken,
  output logic [31:0] ifid_pred_next_pc
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic [31:0]  pend_next;
  logic         pend_taken;
  logic [31:0]  redirect_aligned;
  logic         resp_live;

  ifid_t resp_entry;
  ifid_t ifid_d;
  ifid_t ifid_q;
  ifid_t hold_q;
  logic  ifid_load;
  logic  ifid_bubble;
  logic  hold_load;

  assign current_pc       = pc;
  assign imem_req_addr    = pc;
  assign imem_req_valid   = (state == REQ) && !redirect_valid;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign resp_live        = (state == WAIT) && imem_resp_valid;

  always_comb begin
    resp_entry.valid        = 1'b1;
    resp_entry.pc           = pend_pc;
    resp_entry.inst         = imem_resp_data;
    resp_entry.pred_taken   = pend_taken;
    resp_entry.pred_next_pc = pend_next;
  end

  assign ifid_load   = !stall && (resp_live || (state == HOLD));
  assign ifid_bubble = !stall;
  assign ifid_d      = (state == HOLD) ? hold_q : resp_entry;
  assign hold_load   = resp_live && stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      pc         <= RESET_PC;
      pend_pc    <= 32'h0;
      pend_next  <= 32'h0;
      pend_taken <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_aligned;
      case (state)
        WAIT:    state <= imem_resp_valid ? REQ : DROP;
        DROP:    state <= imem_resp_valid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem_req_ready) begin
            pend_pc    <= pc;
            pend_taken <= predicted_branch_taken;
            pend_next  <= predicted_next_pc;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            pc    <= pend_next;
            state <= stall ? HOLD : REQ;
          end
        end
        HOLD: begin
          if (!stall) state <= REQ;
        end
        DROP: begin
          if (imem_resp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk    (clk),
    .reset  (reset),
    .flush  (redirect_valid),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  fetch_ifid_reg #(.NOP_INST(NOP_INST)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .flush  (redirect_valid),
    .load   (hold_load),
    .bubble (1'b0),
    .d      (resp_entry),
    .q      (hold_q)
  );

  assign ifid_valid        = ifid_q.valid;
  assign ifid_pc           = ifid_q.pc;
  assign ifid_inst         = ifid_q.inst;
  assign ifid_pred_taken   = ifid_q.pred_taken;
  assign ifid_pred_next_pc = ifid_q.pred_next_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level fetch model, predictor and memory models, directed + random stimulus.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] predicted_next_pc;
  logic        predicted_branch_taken;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = 32'h0;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_pred_taken;
  logic [31:0] ifid_pred_next_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk                    (clk),
    .reset                  (reset),
    .current_pc             (current_pc),
    .predicted_next_pc      (predicted_next_pc),
    .predicted_branch_taken (predicted_branch_taken),
    .imem_req_valid         (imem_req_valid),
    .imem_req_addr          (imem_req_addr),
    .imem_req_ready         (imem_req_ready),
    .imem_resp_valid        (imem_resp_valid),
    .imem_resp_data         (imem_resp_data),
    .stall                  (stall),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .ifid_valid             (ifid_valid),
    .ifid_pc                (ifid_pc),
    .ifid_inst              (ifid_inst),
    .ifid_pred_taken        (ifid_pred_taken),
    .ifid_pred_next_pc      (ifid_pred_next_pc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Predictor: one taken entry, otherwise PC+4.
  logic        tk_en = 1'b1;
  logic [31:0] tk_pc = 32'h8;
  logic [31:0] tk_tgt = 32'h40;

  always_comb begin
    predicted_branch_taken = tk_en && (current_pc == tk_pc);
    predicted_next_pc      = predicted_branch_taken ? tk_tgt : current_pc + 32'd4;
  end

  function automatic logic pred_taken_of(input logic [31:0] p);
    return tk_en && (p == tk_pc);
  endfunction

  function automatic logic [31:0] pred_next_of(input logic [31:0] p);
    return pred_taken_of(p) ? tk_tgt : p + 32'd4;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  // Memory: response strobe arrives mem_lat cycles after acceptance.
  int          mem_lat = 1;
  int          mcnt = 0;
  logic [31:0] maddr = 32'h0;

  always @(posedge clk) begin
    if (reset) mcnt = 0;
    else begin
      if (mcnt > 0) mcnt--;
      if (imem_req_valid && imem_req_ready) begin
        mcnt  = mem_lat;
        maddr = imem_req_addr;
      end
    end
    #1;
    imem_resp_valid = (mcnt == 1);
    imem_resp_data  = (mcnt == 1) ? inst_of(maddr) : 32'h0;
  end

  // Reference model: one fetch record in flight, one held record, a discard flag.
  logic        m_started = 1'b0;
  logic [31:0] m_pc;
  logic        out_busy, discard, held_v;
  logic [31:0] o_pc, o_next;
  logic        o_taken;
  logic [31:0] h_pc, h_inst, h_next;
  logic        h_taken;
  logic        e_valid, e_taken;
  logic [31:0] e_pc, e_inst, e_next;
  logic        m_accept, m_deliver;
  logic [31:0] d_pc, d_inst, d_next;
  logic        d_taken;

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1'b1;
      m_pc = 32'h0;
      out_busy = 1'b0; discard = 1'b0; held_v = 1'b0;
      e_valid = 1'b0; e_pc = 32'h0; e_inst = NOP; e_taken = 1'b0; e_next = 32'h0;
    end else if (m_started) begin
      m_accept = !out_busy && !discard && !held_v && !redirect_valid && imem_req_ready;
      if (redirect_valid) begin
        discard  = (out_busy || discard) && !imem_resp_valid;
        out_busy = 1'b0;
        held_v   = 1'b0;
        m_pc     = {redirect_pc[31:2], 2'b00};
        e_valid  = 1'b0;
        e_inst   = NOP;
      end else begin
        m_deliver = 1'b0;
        d_pc = 32'h0; d_inst = 32'h0; d_taken = 1'b0; d_next = 32'h0;
        if (imem_resp_valid && discard) discard = 1'b0;
        else if (imem_resp_valid && out_busy) begin
          out_busy = 1'b0;
          m_pc = o_next;
          if (stall) begin
            held_v = 1'b1; h_pc = o_pc; h_inst = inst_of(o_pc); h_taken = o_taken; h_next = o_next;
          end else begin
            m_deliver = 1'b1; d_pc = o_pc; d_inst = inst_of(o_pc); d_taken = o_taken; d_next = o_next;
          end
        end else if (held_v && !stall) begin
          held_v = 1'b0;
          m_deliver = 1'b1; d_pc = h_pc; d_inst = h_inst; d_taken = h_taken; d_next = h_next;
        end
        if (!stall) begin
          if (m_deliver) begin
            e_valid = 1'b1; e_pc = d_pc; e_inst = d_inst; e_taken = d_taken; e_next = d_next;
          end else begin
            e_valid = 1'b0; e_inst = NOP;
          end
        end
        if (m_accept) begin
          out_busy = 1'b1;
          o_pc = m_pc; o_taken = pred_taken_of(m_pc); o_next = pred_next_of(m_pc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started && !reset) begin
      chk("m_current_pc", current_pc, m_pc);
      chk("m_req_addr", imem_req_addr, m_pc);
      chk("m_req_valid", 32'(imem_req_valid),
          32'(!out_busy && !discard && !held_v && !redirect_valid));
      chk("m_ifid_valid", 32'(ifid_valid), 32'(e_valid));
      chk("m_ifid_inst", ifid_inst, e_inst);
      chk("m_ifid_pc", ifid_pc, e_pc);
      chk("m_ifid_taken", 32'(ifid_pred_taken), 32'(e_taken));
      chk("m_ifid_next", ifid_pred_next_pc, e_next);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, current_pc, 32'h0);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'h0);
    chk({tag, "_ifid_pc"}, ifid_pc, 32'h0);
    chk({tag, "_inst"}, ifid_inst, NOP);
    chk({tag, "_taken"}, 32'(ifid_pred_taken), 32'h0);
    chk({tag, "_next"}, ifid_pred_next_pc, 32'h0);
    chk({tag, "_req_v"}, 32'(imem_req_valid), 32'h1);
    chk({tag, "_req_a"}, imem_req_addr, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; mem_lat = 1;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk_reset_vals("rst0");

    // Sequential fetch, zero-wait memory.
    cyc(); cyc();
    chk("seq0_valid", 32'(ifid_valid), 32'h1);
    chk("seq0_pc", ifid_pc, 32'h0);
    chk("seq0_inst", ifid_inst, 32'hA500_0000);
    chk("seq0_taken", 32'(ifid_pred_taken), 32'h0);
    chk("seq0_req", imem_req_addr, 32'h4);
    cyc(); cyc();
    chk("seq1_pc", ifid_pc, 32'h4);
    chk("seq1_req", imem_req_addr, 32'h8);

    // Taken prediction for pc 0x8.
    cyc(); cyc();
    chk("br_pc", ifid_pc, 32'h8);
    chk("br_taken", 32'(ifid_pred_taken), 32'h1);
    chk("br_next", ifid_pred_next_pc, 32'h40);
    chk("br_req", imem_req_addr, 32'h40);

    // Redirect while waiting on a slow response.
    mem_lat = 3;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("rd_pc", current_pc, 32'h100);
    chk("rd_valid", 32'(ifid_valid), 32'h0);
    chk("rd_inst", ifid_inst, NOP);
    chk("rd_noreq", 32'(imem_req_valid), 32'h0);
    cyc(); cyc();
    chk("rd_req_v", 32'(imem_req_valid), 32'h1);
    chk("rd_req_a", imem_req_addr, 32'h100);
    chk("rd_drop_valid", 32'(ifid_valid), 32'h0);

    // Stall before the response arrives.
    mem_lat = 1;
    cyc(); cyc();
    chk("st_pre_pc", ifid_pc, 32'h100);
    mem_lat = 2; stall = 1'b1;
    cyc(); cyc(); cyc();
    chk("st_hold_valid", 32'(ifid_valid), 32'h1);
    chk("st_hold_pc", ifid_pc, 32'h100);
    chk("st_noreq", 32'(imem_req_valid), 32'h0);
    chk("st_cur_pc", current_pc, 32'h108);
    cyc();
    stall = 1'b0;
    #1;
    chk("st_still_pc", ifid_pc, 32'h100);
    cyc();
    chk("st_rel_pc", ifid_pc, 32'h104);
    chk("st_rel_inst", ifid_inst, 32'hA500_0104);
    chk("st_rel_req", imem_req_addr, 32'h108);

    // Redirect overrides stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    stall = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rs_valid", 32'(ifid_valid), 32'h0);
    chk("rs_inst", ifid_inst, NOP);
    chk("rs_pc", current_pc, 32'h200);

    // Reset in WAIT.
    mem_lat = 3;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_wait");

    // Reset in HOLD.
    mem_lat = 1;
    cyc();
    stall = 1'b1;
    cyc();
    chk("hold_noreq", 32'(imem_req_valid), 32'h0);
    reset = 1'b1;
    cyc();
    reset = 1'b0; stall = 1'b0;
    #1;
    chk_reset_vals("rst_hold");

    // Random traffic checked by the model.
    for (int i = 0; i < 300; i++) begin
      cyc();
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      imem_req_ready = ($urandom_range(0, 2) != 0);
      mem_lat        = $urandom_range(1, 3);
    end
    stall = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    repeat (6) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined core; owns the architectural PC register.
- Drives the branch predictor's current_pc input and consumes predicted_next_pc / predicted_branch_taken combinationally in the same cycle.
- Issues single-outstanding requests to a variable-latency instruction memory and fills the IF/ID pipeline register with the predictor's decision attached.
- Takes stall from the hazard unit and mispredict redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word held in IF/ID when it carries no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- current_pc  out  32  PC register value, to predictor
- predicted_next_pc  in  32  predictor target for current_pc
- predicted_branch_taken  in  1  predictor decision for current_pc
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  32  fetch address (= current_pc)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response strobe
- imem_resp_data  in  32  instruction word
- stall  in  1  ID cannot accept; hold IF/ID
- redirect_valid  in  1  EX mispredict/flush
- redirect_pc  in  32  correct next PC
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  32  PC of the IF/ID instruction
- ifid_inst  out  32  instruction word
- ifid_pred_taken  out  1  predictor decision used
- ifid_pred_next_pc  out  32  predicted next PC used, for EX compare

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - pc=RESET_PC; state=REQ.
  - ifid_valid=0, ifid_pc=0, ifid_inst=NOP_INST, ifid_pred_taken=0, ifid_pred_next_pc=0.
  - Hold buffer empty; pending registers 0.
  - Reset mid-transaction abandons any outstanding response. The memory must also be reset in the same cycle.
- States: REQ, WAIT, HOLD, DROP.
- imem_req_valid=1 only in REQ with redirect_valid=0. imem_req_addr=pc.
- REQ:
  - On valid&&ready: latch pend_pc=pc, pend_taken=predicted_branch_taken, pend_next=predicted_next_pc; go to WAIT.
  - Not accepted: remain in REQ; pc unchanged.
- WAIT, imem_resp_valid=1 (response at least 1 cycle after accept):
  - stall=0: write IF/ID {1, pend_pc, resp_data, pend_taken, pend_next}; pc<=pend_next; go to REQ.
  - stall=1: store response in the hold buffer; pc<=pend_next; go to HOLD.
- HOLD: no requests issued. When stall=0, move the hold buffer into IF/ID and go to REQ.
- IF/ID update rules:
  - stall=1: IF/ID retains its value.
  - stall=0 with no instruction delivered this cycle: ifid_valid<=0, ifid_inst<=NOP_INST (bubble).
- Redirect (highest priority, overrides stall):
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - ifid_valid<=0, ifid_inst<=NOP_INST; hold buffer cleared.
  - From REQ or HOLD: go to REQ.
  - From WAIT: if a response arrives the same cycle, discard it and go to REQ; otherwise go to DROP.
  - In DROP: discard the next response and go to REQ. A further redirect while in DROP only updates pc.
- Next-PC sequencing uses the prediction captured at request acceptance, not the live predictor output.
- Zero-wait memory (ready=1, response 1 cycle later) gives one instruction per 2 cycles; throughput optimisation is out of scope.
- Arithmetic is 32-bit; pc wraps modulo 2^32 via the predictor's PC+4.

Decomposition:
- Package fetch_pkg holds:
  - state enum {REQ, WAIT, HOLD, DROP};
  - NOP_INST and RESET_PC defaults;
  - a packed IF/ID struct {valid, pc, inst, pred_taken, pred_next_pc}.
- One sub-module, fetch_ifid_reg: the IF/ID register with load/hold/bubble/flush controls, reused for the hold buffer.

Test Plan:
- Reset then release; memory ready=1 with 1-cycle response; predictor not-taken -> requests at 0x0, 0x4, 0x8 on every other cycle; ifid_pc 0x0 valid 2 cycles after first request; ifid_pred_taken=0.
- Predictor returns taken=1, target 0x40 for pc 0x8 -> next request address 0x40; ifid_pred_next_pc=0x40 alongside ifid_pc=0x8.
- Redirect to 0x100 while in WAIT; response arrives 2 cycles later -> response discarded, ifid_valid=0, next request at 0x100.
- stall=1 asserted before a response arrives, held 3 cycles -> IF/ID unchanged, no request issued; on stall=0 the held instruction appears in IF/ID the next cycle.
- redirect_valid=1 and stall=1 in the same cycle with ifid_valid=1 -> ifid_valid=0, ifid_inst=0x00000013, pc=redirect_pc.
- reset asserted in WAIT and in HOLD -> all outputs at reset values next cycle; first request at RESET_PC.
